// File: rtl/stream_to_mem_arb.sv
// Arbitrates NumChan request streams onto one memory port and routes the in-order memory
// responses back to the originating channel through per-channel fall-through buffers.
module stream_to_mem_arb #(
    parameter type         mem_req_t      = logic,
    parameter type         mem_resp_t     = logic,
    parameter int unsigned NumChan        = 2,
    parameter int unsigned BufDepth       = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  mem_req_t           req_i        [NumChan],
    input  logic [NumChan-1:0] req_valid_i,
    output logic [NumChan-1:0] req_ready_o,
    output mem_resp_t          resp_o       [NumChan],
    output logic [NumChan-1:0] resp_valid_o,
    input  logic [NumChan-1:0] resp_ready_i,
    output mem_req_t           mem_req_o,
    output logic               mem_req_valid_o,
    input  logic               mem_req_ready_i,
    input  mem_resp_t          mem_resp_i,
    input  logic               mem_resp_valid_i,
    output logic               idle_o
);

    localparam int unsigned IdxW  = (NumChan > 1) ? $clog2(NumChan) : 1;
    localparam int unsigned CntW  = $clog2(BufDepth + 1);
    localparam int unsigned BufAw = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam int unsigned IdAw  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned IdCw  = $clog2(MaxOutstanding + 1);

    logic [CntW-1:0]    cnt_q      [NumChan];
    logic [CntW-1:0]    cnt_d      [NumChan];
    logic [IdxW-1:0]    rr_q, rr_d;
    logic               lock_q, lock_d;
    logic [IdxW-1:0]    lock_idx_q, lock_idx_d;

    logic [IdxW-1:0]    id_mem_q   [MaxOutstanding];
    logic [IdAw-1:0]    id_wr_q, id_wr_d;
    logic [IdAw-1:0]    id_rd_q, id_rd_d;
    logic [IdCw-1:0]    id_cnt_q, id_cnt_d;

    mem_resp_t          buf_q      [NumChan][BufDepth];
    logic [BufAw-1:0]   buf_wr_q   [NumChan];
    logic [BufAw-1:0]   buf_wr_d   [NumChan];
    logic [BufAw-1:0]   buf_rd_q   [NumChan];
    logic [BufAw-1:0]   buf_rd_d   [NumChan];
    logic [CntW-1:0]    buf_cnt_q  [NumChan];
    logic [CntW-1:0]    buf_cnt_d  [NumChan];

    logic [NumChan-1:0] credit, eligible;
    logic [NumChan-1:0] resp_push, resp_pop, buf_we, buf_pop, buf_empty;
    logic               id_empty, id_full, id_pop, gate, mem_hs;
    logic               any_elig, sel_valid;
    logic [IdxW-1:0]    rr_idx, grant, id_head;

    // ID FIFO: remembers which channel issued each outstanding memory request.
    assign id_empty = (id_cnt_q == '0);
    assign id_full  = (id_cnt_q == IdCw'(MaxOutstanding));
    assign id_pop   = mem_resp_valid_i && !id_empty && !rst_i;
    assign id_head  = id_mem_q[id_rd_q];

    always_comb begin
        resp_push    = '0;
        resp_pop     = '0;
        resp_valid_o = '0;
        buf_empty    = '0;
        for (int c = 0; c < NumChan; c++) begin
            buf_empty[c]    = (buf_cnt_q[c] == '0);
            resp_push[c]    = id_pop && (id_head == IdxW'(c));
            resp_valid_o[c] = !rst_i && (!buf_empty[c] || resp_push[c]);
            resp_o[c]       = buf_empty[c] ? mem_resp_i : buf_q[c][buf_rd_q[c]];
            resp_pop[c]     = resp_valid_o[c] && resp_ready_i[c];
        end
    end

    // Round robin: lowest eligible index at or above rr wins, else lowest eligible overall.
    always_comb begin
        credit   = '0;
        eligible = '0;
        for (int c = 0; c < NumChan; c++) begin
            credit[c]   = (cnt_q[c] < CntW'(BufDepth)) || resp_pop[c];
            eligible[c] = req_valid_i[c] && credit[c];
        end
        any_elig = |eligible;
        rr_idx   = '0;
        for (int c = NumChan - 1; c >= 0; c--) begin
            if (eligible[c]) begin
                rr_idx = IdxW'(c);
            end
        end
        for (int c = NumChan - 1; c >= 0; c--) begin
            if (eligible[c] && (IdxW'(c) >= rr_q)) begin
                rr_idx = IdxW'(c);
            end
        end
    end

    assign grant           = lock_q ? lock_idx_q : rr_idx;
    assign sel_valid       = lock_q ? eligible[lock_idx_q] : any_elig;
    assign gate            = !id_full || id_pop;
    assign mem_req_valid_o = !rst_i && sel_valid && gate;
    assign mem_req_o       = req_i[grant];
    assign mem_hs          = mem_req_valid_o && mem_req_ready_i;

    always_comb begin
        req_ready_o = '0;
        for (int c = 0; c < NumChan; c++) begin
            req_ready_o[c] = mem_hs && (grant == IdxW'(c));
        end
    end

    assign idle_o = rst_i || (id_empty && (&buf_empty));

    // Arbiter state, credit counters and ID FIFO pointers.
    always_comb begin
        rr_d       = rr_q;
        lock_d     = mem_req_valid_o && !mem_req_ready_i;
        lock_idx_d = grant;
        if (mem_hs && (NumChan > 1)) begin
            rr_d = (grant == IdxW'(NumChan - 1)) ? '0 : grant + IdxW'(1);
        end

        for (int c = 0; c < NumChan; c++) begin
            cnt_d[c] = cnt_q[c];
            if (req_ready_o[c] && !resp_pop[c]) begin
                cnt_d[c] = cnt_q[c] + CntW'(1);
            end else if (!req_ready_o[c] && resp_pop[c]) begin
                cnt_d[c] = cnt_q[c] - CntW'(1);
            end
        end

        id_wr_d  = id_wr_q;
        id_rd_d  = id_rd_q;
        id_cnt_d = id_cnt_q;
        if (mem_hs) begin
            id_wr_d = (id_wr_q == IdAw'(MaxOutstanding - 1)) ? '0 : id_wr_q + IdAw'(1);
        end
        if (id_pop) begin
            id_rd_d = (id_rd_q == IdAw'(MaxOutstanding - 1)) ? '0 : id_rd_q + IdAw'(1);
        end
        if (mem_hs && !id_pop) begin
            id_cnt_d = id_cnt_q + IdCw'(1);
        end else if (!mem_hs && id_pop) begin
            id_cnt_d = id_cnt_q - IdCw'(1);
        end
    end

    // A response consumed in its arrival cycle bypasses the buffer entirely.
    always_comb begin
        buf_we  = '0;
        buf_pop = '0;
        for (int c = 0; c < NumChan; c++) begin
            buf_we[c]    = resp_push[c] && !(buf_empty[c] && resp_pop[c]);
            buf_pop[c]   = resp_pop[c] && !buf_empty[c];
            buf_wr_d[c]  = buf_wr_q[c];
            buf_rd_d[c]  = buf_rd_q[c];
            buf_cnt_d[c] = buf_cnt_q[c];
            if (buf_we[c]) begin
                buf_wr_d[c] = (buf_wr_q[c] == BufAw'(BufDepth - 1)) ? '0
                                                                    : buf_wr_q[c] + BufAw'(1);
            end
            if (buf_pop[c]) begin
                buf_rd_d[c] = (buf_rd_q[c] == BufAw'(BufDepth - 1)) ? '0
                                                                    : buf_rd_q[c] + BufAw'(1);
            end
            if (buf_we[c] && !buf_pop[c]) begin
                buf_cnt_d[c] = buf_cnt_q[c] + CntW'(1);
            end else if (!buf_we[c] && buf_pop[c]) begin
                buf_cnt_d[c] = buf_cnt_q[c] - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            id_wr_q    <= '0;
            id_rd_q    <= '0;
            id_cnt_q   <= '0;
            for (int c = 0; c < NumChan; c++) begin
                cnt_q[c]     <= '0;
                buf_wr_q[c]  <= '0;
                buf_rd_q[c]  <= '0;
                buf_cnt_q[c] <= '0;
            end
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            id_wr_q    <= id_wr_d;
            id_rd_q    <= id_rd_d;
            id_cnt_q   <= id_cnt_d;
            for (int c = 0; c < NumChan; c++) begin
                cnt_q[c]     <= cnt_d[c];
                buf_wr_q[c]  <= buf_wr_d[c];
                buf_rd_q[c]  <= buf_rd_d[c];
                buf_cnt_q[c] <= buf_cnt_d[c];
            end
        end
    end

    // Storage arrays need no reset; their occupancy is tracked by the pointers above.
    always_ff @(posedge clk_i) begin
        if (mem_hs) begin
            id_mem_q[id_wr_q] <= grant;
        end
        for (int c = 0; c < NumChan; c++) begin
            if (buf_we[c]) begin
                buf_q[c][buf_wr_q[c]] <= mem_resp_i;
            end
        end
    end

    resp_without_request: assert property (
        @(posedge clk_i) disable iff (rst_i) mem_resp_valid_i |-> !id_empty);

    for (genvar g = 0; g < NumChan; g++) begin : gen_buf_chk
        buf_overflow: assert property (
            @(posedge clk_i) disable iff (rst_i)
            !(buf_we[g] && !buf_pop[g] && (buf_cnt_q[g] == CntW'(BufDepth))));
    end

endmodule

// File: tb/tb_stream_to_mem_arb.sv
// Scoreboard bench for stream_to_mem_arb: NumChan=2, BufDepth=2, MaxOutstanding=4.
module tb_stream_to_mem_arb;

    typedef logic [15:0] word_t;

    logic       clk = 1'b0;
    logic       rst;
    word_t      req        [2];
    logic [1:0] req_valid, req_ready;
    word_t      resp       [2];
    logic [1:0] resp_valid, resp_ready;
    word_t      mem_req, mem_resp;
    logic       mem_req_valid, mem_req_ready, mem_resp_valid, idle;

    always #5 clk = ~clk;

    stream_to_mem_arb #(
        .mem_req_t      (word_t),
        .mem_resp_t     (word_t),
        .NumChan        (2),
        .BufDepth       (2),
        .MaxOutstanding (4)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (req),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .resp_o           (resp),
        .resp_valid_o     (resp_valid),
        .resp_ready_i     (resp_ready),
        .mem_req_o        (mem_req),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_resp_i       (mem_resp),
        .mem_resp_valid_i (mem_resp_valid),
        .idle_o           (idle)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus controls and scoreboard state.
    int         en [2], left [2], seq [2], hs_cnt [2], rcv_cnt [2];
    logic [1:0] rdy;
    logic       mem_rdy, rst_req;
    int         lat, cyc, max_out;
    word_t      exp_q [2][$];
    word_t      mdata_q [$];
    int         mdue_q [$];
    int         glog [$];

    logic [1:0] o_req_ready, o_resp_valid;
    logic       o_mem_valid, o_idle;
    word_t      o_mem_req;

    function automatic word_t pay(input int c, input int s);
        return {c[3:0], 4'hA, s[7:0]};
    endfunction

    task automatic cycle();
        int gc;
        @(negedge clk);
        rst = rst_req;
        for (int c = 0; c < 2; c++) begin
            req_valid[c]  = (en[c] != 0) && (left[c] > 0);
            req[c]        = pay(c, seq[c]);
            resp_ready[c] = rdy[c];
        end
        mem_req_ready  = mem_rdy;
        mem_resp_valid = 1'b0;
        mem_resp       = '0;
        if (mdata_q.size() > 0) begin
            mem_resp_valid = (mdue_q[0] <= cyc);
            mem_resp       = ~mdata_q[0];
        end
        #1;
        o_req_ready  = req_ready;
        o_resp_valid = resp_valid;
        o_mem_valid  = mem_req_valid;
        o_idle       = idle;
        o_mem_req    = mem_req;
        if (rst_req) begin
            mdata_q.delete();
            mdue_q.delete();
            exp_q[0].delete();
            exp_q[1].delete();
        end else begin
            if (mem_resp_valid) begin
                void'(mdata_q.pop_front());
                void'(mdue_q.pop_front());
            end
            if (mem_req_valid && mem_req_ready) begin
                check_eq("ready_onehot", $countones(req_ready), 1);
                gc = -1;
                for (int c = 0; c < 2; c++) if (req_ready[c]) gc = c;
                glog.push_back(gc);
                if (gc >= 0) check_eq("mem_payload", mem_req, req[gc]);
                mdata_q.push_back(mem_req);
                mdue_q.push_back(cyc + lat);
                if (mdata_q.size() > max_out) max_out = mdata_q.size();
                check_eq("outstanding_le4", mdata_q.size() <= 4, 1);
            end else begin
                check_eq("ready_without_hs", req_ready, 0);
            end
            for (int c = 0; c < 2; c++) begin
                if (req_valid[c] && req_ready[c]) begin
                    exp_q[c].push_back(~req[c]);
                    seq[c]++;
                    left[c]--;
                    hs_cnt[c]++;
                end
                if (resp_valid[c] && resp_ready[c]) begin
                    check_eq($sformatf("resp_expected_ch%0d", c), exp_q[c].size() > 0, 1);
                    if (exp_q[c].size() > 0) begin
                        check_eq($sformatf("resp_data_ch%0d", c), resp[c], exp_q[c].pop_front());
                    end
                    rcv_cnt[c]++;
                end
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        int b0, b1;
        word_t p0;
        rst = 1'b1; req_valid = '0; resp_ready = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp = '0; req[0] = '0; req[1] = '0;
        en = '{1, 1}; left = '{4, 4}; seq = '{0, 0}; hs_cnt = '{0, 0}; rcv_cnt = '{0, 0};
        rdy = 2'b11; mem_rdy = 1'b1; rst_req = 1'b1; lat = 1; cyc = 0; max_out = 0;

        // Reset with requests already pending: nothing may leak out.
        repeat (2) begin
            cycle();
            check_eq("rst_mem_valid", o_mem_valid, 0);
            check_eq("rst_req_ready", o_req_ready, 0);
            check_eq("rst_resp_valid", o_resp_valid, 0);
            check_eq("rst_idle", o_idle, 1);
        end
        rst_req = 1'b0;

        // Both channels streaming: strict alternation starting at channel 0.
        glog.delete();
        run(16);
        check_eq("alt_count", glog.size(), 8);
        for (int i = 0; i < 8; i++) check_eq($sformatf("alt_grant%0d", i), glog[i], i % 2);
        check_eq("alt_rcv0", rcv_cnt[0], 4);
        check_eq("alt_rcv1", rcv_cnt[1], 4);

        // Channel 0 backpressured: two credits only, channel 1 unaffected.
        b0 = hs_cnt[0]; b1 = rcv_cnt[1];
        rdy = 2'b10; left[0] = 3; left[1] = 4;
        run(14);
        check_eq("bp_ch0_accepted", hs_cnt[0] - b0, 2);
        check_eq("bp_ch0_blocked", o_req_ready[0], 0);
        check_eq("bp_ch1_rcv", rcv_cnt[1] - b1, 4);
        rdy = 2'b11;
        run(10);
        check_eq("bp_ch0_drained", left[0], 0);
        check_eq("bp_ch0_exp_empty", exp_q[0].size(), 0);

        // Grant lock while the memory port stalls.
        mem_rdy = 1'b0; en[1] = 0; left[0] = 1; left[1] = 1;
        p0 = pay(0, seq[0]);
        cycle();
        check_eq("lock_valid", o_mem_valid, 1);
        check_eq("lock_first", o_mem_req, p0);
        en[1] = 1;
        repeat (2) begin
            cycle();
            check_eq("lock_hold", o_mem_req, p0);
            check_eq("lock_no_ready", o_req_ready, 0);
        end
        mem_rdy = 1'b1;
        glog.delete();
        run(6);
        check_eq("lock_hs_count", glog.size(), 2);
        check_eq("lock_order0", glog[0], 0);
        check_eq("lock_order1", glog[1], 1);

        // Memory latency 5: outstanding caps at 4, every response delivered.
        lat = 5; left = '{6, 6}; max_out = 0;
        b0 = rcv_cnt[0]; b1 = rcv_cnt[1];
        run(60);
        check_eq("lat5_max_out", max_out, 4);
        check_eq("lat5_rcv0", rcv_cnt[0] - b0, 6);
        check_eq("lat5_rcv1", rcv_cnt[1] - b1, 6);
        lat = 1;

        // Full credit on ch0 with a pop and a grant in the same cycle.
        en[1] = 0; rdy = 2'b10; left[0] = 2;
        run(6);
        check_eq("cnt_full_buffered", o_resp_valid[0], 1);
        left[0] = 2;
        cycle();
        check_eq("cnt_full_block", o_req_ready[0], 0);
        rdy[0] = 1'b1;
        cycle();
        check_eq("pop_and_grant", o_req_ready[0], 1);
        rdy[0] = 1'b0;
        run(3);
        check_eq("cnt_stays_full", o_req_ready[0], 0);
        check_eq("cnt_left", left[0], 1);
        rdy = 2'b11;
        run(8);
        check_eq("cnt_drained", left[0], 0);
        check_eq("cnt_exp_empty", exp_q[0].size(), 0);

        // Reset with three requests outstanding.
        lat = 5; en = '{1, 1}; left[0] = 2; left[1] = 1;
        for (int i = 0; i < 10 && mdata_q.size() < 3; i++) cycle();
        check_eq("three_outstanding", mdata_q.size(), 3);
        rst_req = 1'b1; en = '{0, 0};
        cycle();
        check_eq("midrst_mem_valid", o_mem_valid, 0);
        rst_req = 1'b0;
        cycle();
        check_eq("post_rst_idle", o_idle, 1);
        check_eq("post_rst_resp", o_resp_valid, 0);
        lat = 1; en = '{1, 1}; left = '{2, 2};
        glog.delete();
        run(10);
        check_eq("post_rst_hs", glog.size(), 4);
        check_eq("post_rst_first_ch0", glog[0], 0);
        check_eq("post_rst_rcv_done", exp_q[0].size() + exp_q[1].size(), 0);
        check_eq("final_idle", o_idle, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/stream_to_mem_arb.md
STREAM_TO_MEM_ARB -- requirements
Module: stream_to_mem_arb

Interface
REQ-001 Parameter mem_req_t, default logic, memory request payload type.
REQ-002 Parameter mem_resp_t, default logic, memory response payload type.
REQ-003 Parameter NumChan, default 2, number of request/response stream channels, >=1.
REQ-004 Parameter BufDepth, default 1, per-channel response buffer depth and per-channel outstanding limit, >=1.
REQ-005 Parameter MaxOutstanding, default 2, total outstanding requests on the memory port (ID FIFO depth), >=1.
REQ-006 clk_i  in  1  clock; single clock domain, all logic on rising edge.
REQ-007 rst_i  in  1  reset, synchronous, active-high.
REQ-008 req_i  in  NumChan x mem_req_t  per-channel request payload.
REQ-009 req_valid_i  in  NumChan  per-channel request valid.
REQ-010 req_ready_o  out  NumChan  per-channel request ready.
REQ-011 resp_o  out  NumChan x mem_resp_t  per-channel response payload.
REQ-012 resp_valid_o  out  NumChan  per-channel response valid.
REQ-013 resp_ready_i  in  NumChan  per-channel response ready.
REQ-014 mem_req_o / mem_req_valid_o / mem_req_ready_i  out/out/in  mem_req_t/1/1  memory request stream.
REQ-015 mem_resp_i / mem_resp_valid_i  in/in  mem_resp_t/1  memory response, no backpressure, in order, latency >=1 cycle.
REQ-016 idle_o  out  1  high when no request outstanding and all response buffers empty.

Function
REQ-017 Channel c eligible iff req_valid_i[c] and credit[c] available: cnt[c] < BufDepth, or resp_valid_o[c] & resp_ready_i[c] this cycle.
REQ-018 Global gate: ID FIFO not full, or ID FIFO popped this cycle (mem_resp_valid_i).
REQ-019 Round-robin arbitration among eligible channels, starting search at pointer rr; winner g.
REQ-020 mem_req_valid_o = any eligible & global gate; mem_req_o = req_i[g].
REQ-021 req_ready_o[c] = (c == g) & mem_req_valid_o & mem_req_ready_i; all others 0.
REQ-022 Grant lock: if mem_req_valid_o & !mem_req_ready_i, next cycle g unchanged (channel held; requesters obey stream stability).
REQ-023 On memory handshake: push g into ID FIFO, cnt[g] +1, rr <= (g+1) mod NumChan; no handshake -> rr unchanged.
REQ-024 On mem_resp_valid_i: pop ID FIFO head h, push mem_resp_i into channel h fall-through FIFO; zero added latency (resp_valid_o[h] same cycle if buffer empty).
REQ-025 On resp_valid_o[c] & resp_ready_i[c]: pop channel c FIFO, cnt[c] -1.
REQ-026 Simultaneous +1 and -1 on same cnt[c]: cnt[c] unchanged.
REQ-027 cnt[c] width $clog2(BufDepth+1) bits; never exceeds BufDepth, never underflows.
REQ-028 Each channel response FIFO independent; backpressure on one channel never blocks other channels' responses.
REQ-029 Channel FIFO always has space for an arriving response (guaranteed by credit); overflow is an assertion failure.
REQ-030 mem_resp_valid_i with ID FIFO empty is an assertion failure; response dropped.
REQ-031 NumChan = 1: arbiter degenerates to pass-through, rr fixed at 0.
REQ-032 Data payloads not modified.

Reset
REQ-033 rst_i high at a clock edge: cnt all 0, rr 0, ID FIFO empty, all channel FIFOs empty, grant lock cleared.
REQ-034 During and after reset until first request: resp_valid_o all 0, req_ready_o all 0 (since mem_req_valid_o requires rst_i low), idle_o 1.
REQ-035 Reset mid-operation discards outstanding IDs and buffered responses; memory responses arriving after reset for pre-reset requests are the integrator's responsibility.

Verification (NumChan=2, BufDepth=2, MaxOutstanding=4, memory latency 1 unless stated)
REQ-036 Both channels valid continuously, mem ready always -> grants alternate 0,1,0,1; each response returned to originating channel in order.
REQ-037 Channel 0 resp_ready_i=0, 3 requests on ch0 -> 2 accepted, 3rd req_ready_o[0]=0 until one ch0 response popped; ch1 traffic continues unaffected.
REQ-038 mem_req_ready_i=0 for 3 cycles with ch0 granted, ch1 valid meanwhile -> mem_req_o stays ch0 payload, ch0 handshakes first, then ch1.
REQ-039 Memory latency 5, ch0 and ch1 streaming -> at most 4 outstanding; 5th request stalls until first response; no response lost.
REQ-040 cnt[0]=2, ch0 response popped same cycle as new ch0 request granted -> request accepted, cnt[0] stays 2.
REQ-041 rst_i asserted with 3 outstanding -> next cycle idle_o=1, all resp_valid_o=0, grant restarts at channel 0.
